// File: rtl/field_writer_if.sv
// field_writer_if: valid/ready packet stream bundle for the field rewriter.
// Ports: in_* upstream beat with field_in/field_en capture, in_ready back;
// out_* downstream beat, out_ready back; err framing pulse.
interface field_writer_if #(
    parameter int W  = 32,
    parameter int FW = 8
);
    logic [W-1:0]  in_data;
    logic          in_sop;
    logic          in_eop;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] field_in;
    logic          field_en;
    logic [W-1:0]  out_data;
    logic          out_sop;
    logic          out_eop;
    logic          out_valid;
    logic          out_ready;
    logic          err;

    modport master (
        output in_data, in_sop, in_eop, in_valid, field_in, field_en, out_ready,
        input  in_ready, out_data, out_sop, out_eop, out_valid, err
    );

    modport slave (
        input  in_data, in_sop, in_eop, in_valid, field_in, field_en, out_ready,
        output in_ready, out_data, out_sop, out_eop, out_valid, err
    );
endinterface

// File: rtl/field_writer.sv
// field_writer: overwrites packet bits [END:START] as beats stream through one register stage.
// Ports: clk, reset (sync, active-high); bus.slave carries the input stream,
// the replacement field, the output stream and the err framing pulse.
module field_writer #(
    parameter int W         = 32,
    parameter int START     = 2,
    parameter int END       = 9,
    parameter int MAX_BEATS = 64
) (
    input logic         clk,
    input logic         reset,
    field_writer_if.slave bus
);
    localparam int FW = END - START + 1;
    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam int EW = FW + 2 * W;
    localparam logic [EW-1:0] MSK = {{W{1'b0}}, {FW{1'b1}}, {W{1'b0}}};

    typedef enum logic {IDLE, PKT} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [FW-1:0] r_field;
    logic          r_en;

    logic          w_acc;
    logic [FW-1:0] w_fld;
    logic [CW-1:0] w_idx;
    logic          w_en;
    logic          w_hit;
    int            w_off;
    int            w_sh;
    logic [EW-1:0] w_ext;
    logic [W-1:0]  w_alg;
    logic [W-1:0]  w_msk;
    logic [W-1:0]  w_out;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;

    // The field is padded by W zeros each side so one right shift aligns it
    // to the lane; w_off is the field bit that lands on lane bit 0.
    always_comb begin
        w_acc = bus.in_valid && bus.in_ready;
        w_fld = bus.in_sop ? bus.field_in : r_field;
        w_idx = bus.in_sop ? '0 : r_cnt;
        w_en  = (bus.in_sop ? bus.field_en : (r_state == PKT && r_en)) && w_idx != CW'(MAX_BEATS);
        w_off = int'(w_idx) * W - START;
        w_hit = w_en && w_off > -W && w_off < FW;
        w_sh  = w_hit ? w_off + W : 0;
        w_ext = {{W{1'b0}}, w_fld, {W{1'b0}}};
        w_alg = W'(w_ext >> w_sh);
        w_msk = W'(MSK >> w_sh);
        w_out = w_hit ? ((bus.in_data & ~w_msk) | (w_alg & w_msk)) : bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_field       <= '0;
            r_en          <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sop   <= 1'b0;
            bus.out_eop   <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.err       <= 1'b0;
        end else if (w_acc) begin
            bus.out_data  <= w_out;
            bus.out_sop   <= bus.in_sop;
            bus.out_eop   <= bus.in_eop;
            bus.out_valid <= 1'b1;
            bus.err       <= bus.in_sop ? (r_state == PKT) : (r_state == IDLE);
            if (bus.in_sop) begin
                r_field <= bus.field_in;
                r_en    <= bus.field_en;
                r_cnt   <= CW'(1);
                r_state <= bus.in_eop ? IDLE : PKT;
            end else if (r_state == PKT) begin
                r_cnt   <= (r_cnt == CW'(MAX_BEATS)) ? r_cnt : r_cnt + CW'(1);
                r_state <= bus.in_eop ? IDLE : PKT;
            end
        end else begin
            bus.err <= 1'b0;
            if (bus.out_ready) bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_field_writer.sv
// tb_field_writer: directed and randomized checks of field_writer against a queue scoreboard.
// Ports: none; drives two instances (W=8/START=4/END=11/MAX_BEATS=4 and defaults).
module tb_field_writer;
    localparam int W = 8, ST = 4, EN = 11, MAXB = 4;

    typedef struct packed {
        logic [W-1:0] d;
        logic         s;
        logic         e;
    } beat_t;

    logic clk, reset;
    int tests = 0, fails = 0;

    beat_t q[$];
    bit in_pkt;
    int cnt;
    logic [W-1:0] fld;
    bit en;
    bit exp_err;

    field_writer_if #(.W(W), .FW(EN - ST + 1)) b();
    field_writer_if #(.W(32), .FW(8)) b2();

    field_writer #(.W(W), .START(ST), .END(EN), .MAX_BEATS(MAXB)) u (.clk(clk), .reset(reset), .bus(b));
    field_writer u2 (.clk(clk), .reset(reset), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packet bit p = idx*W + j takes field bit p-START inside the window.
    function automatic logic [W-1:0] rewrite(input logic [W-1:0] d, input int idx,
                                             input logic [W-1:0] f, input bit e);
        logic [W-1:0] r = d;
        for (int j = 0; j < W; j++) begin
            int p = idx * W + j;
            if (e && idx < MAXB && p >= ST && p <= EN) r[j] = f[p - ST];
        end
        return r;
    endfunction

    task automatic step();
        bit rdy, acc, tr, hold, ferr, en_eff;
        beat_t nb;
        logic [W-1:0] prev;
        int idx;
        #1;
        rdy = (q.size() == 0) || b.out_ready;
        chk("in_ready", 32'(b.in_ready), 32'(rdy));
        acc = b.in_valid && rdy;
        tr = (q.size() != 0) && b.out_ready;
        hold = (q.size() != 0) && !b.out_ready;
        prev = b.out_data;
        ferr = 1'b0;
        nb = '0;
        idx = 0;
        en_eff = 1'b0;
        if (acc) begin
            ferr = b.in_sop ? in_pkt : !in_pkt;
            if (b.in_sop) begin
                fld = b.field_in;
                en = b.field_en;
                en_eff = en;
                cnt = 1;
            end else if (in_pkt) begin
                idx = cnt;
                en_eff = en;
                cnt = (cnt < MAXB) ? cnt + 1 : cnt;
            end
            in_pkt = (b.in_sop || in_pkt) && !b.in_eop;
            nb.d = rewrite(b.in_data, idx, fld, en_eff);
            nb.s = b.in_sop;
            nb.e = b.in_eop;
        end
        @(posedge clk);
        #1;
        if (tr) void'(q.pop_front());
        if (acc) q.push_back(nb);
        exp_err = acc && ferr;
        chk("out_valid", 32'(b.out_valid), 32'(q.size() != 0));
        chk("err", 32'(b.err), 32'(exp_err));
        chk("depth", 32'(q.size() <= 1), 32'(1));
        if (q.size() != 0) begin
            chk("out_data", 32'(b.out_data), 32'(q[0].d));
            chk("out_sop", 32'(b.out_sop), 32'(q[0].s));
            chk("out_eop", 32'(b.out_eop), 32'(q[0].e));
        end
        if (hold) chk("hold_stable", 32'(b.out_data), 32'(prev));
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] d, input bit s, input bit e,
                        input logic [W-1:0] f, input bit fe);
        b.in_valid = 1'b1;
        b.in_data = d;
        b.in_sop = s;
        b.in_eop = e;
        b.field_in = f;
        b.field_en = fe;
        b.out_ready = 1'b1;
        step();
        b.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        b.in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        in_pkt = 1'b0;
        cnt = 0;
        fld = '0;
        en = 1'b0;
        chk("rst_out_valid", 32'(b.out_valid), 32'(0));
        chk("rst_out_data", 32'(b.out_data), 32'(0));
        chk("rst_out_sop", 32'(b.out_sop), 32'(0));
        chk("rst_out_eop", 32'(b.out_eop), 32'(0));
        chk("rst_err", 32'(b.err), 32'(0));
        chk("rst_in_ready", 32'(b.in_ready), 32'(1));
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        {b.in_data, b.in_sop, b.in_eop, b.in_valid, b.field_in, b.field_en} = '0;
        b.out_ready = 1'b1;
        {b2.in_data, b2.in_sop, b2.in_eop, b2.in_valid, b2.field_in, b2.field_en} = '0;
        b2.out_ready = 1'b1;
        @(negedge clk);
        do_reset();

        b2.in_valid = 1'b1;
        b2.in_sop = 1'b1;
        b2.in_eop = 1'b1;
        b2.in_data = 32'hFFFF_FFFF;
        b2.field_en = 1'b1;
        @(posedge clk);
        #1;
        chk("def_data", b2.out_data, 32'hFFFF_FC03);
        chk("def_sop_eop", 32'({b2.out_sop, b2.out_eop}), 32'h3);
        chk("def_err", 32'(b2.err), 32'(0));
        @(negedge clk);
        b2.in_sop = 1'b0;
        b2.in_eop = 1'b0;
        b2.in_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        chk("def_idle_err", 32'(b2.err), 32'(1));
        chk("def_idle_data", b2.out_data, 32'h1234_5678);
        @(negedge clk);
        b2.in_valid = 1'b0;

        send(8'h00, 1, 0, 8'hA5, 1); chk("p1_b0", 32'(b.out_data), 32'h50);
        chk("p1_sop", 32'(b.out_sop), 32'(1));
        send(8'h00, 0, 0, 8'h00, 0); chk("p1_b1", 32'(b.out_data), 32'h0A);
        send(8'h00, 0, 1, 8'h00, 0); chk("p1_b2", 32'(b.out_data), 32'h00);
        chk("p1_eop", 32'(b.out_eop), 32'(1));

        send(8'hFF, 1, 0, 8'hA5, 0); chk("p2_b0", 32'(b.out_data), 32'hFF);
        send(8'hFF, 0, 0, 8'h00, 1); chk("p2_b1", 32'(b.out_data), 32'hFF);
        send(8'hFF, 0, 1, 8'h00, 1); chk("p2_b2", 32'(b.out_data), 32'hFF);

        send(8'h00, 1, 0, 8'h3C, 1);
        b.in_valid = 1'b1;
        b.out_ready = 1'b0;
        b.in_sop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b.in_data = 8'($urandom);
            step();
        end
        b.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b.in_data = 8'($urandom);
            b.in_eop = (i == 3);
            step();
        end
        b.in_valid = 1'b0;
        b.in_eop = 1'b0;

        send(8'h00, 1, 0, 8'h3C, 1); chk("fr_b0", 32'(b.out_data), 32'h C0);
        send(8'h00, 1, 0, 8'h5A, 1); chk("fr_sop_pkt", 32'(b.out_data), 32'hA0);
        chk("fr_sop_err", 32'(b.err), 32'(1));
        send(8'h00, 0, 1, 8'h00, 0); chk("fr_b1", 32'(b.out_data), 32'h05);
        send(8'h77, 0, 0, 8'hFF, 1); chk("fr_idle", 32'(b.out_data), 32'h77);
        chk("fr_idle_err", 32'(b.err), 32'(1));

        send(8'h00, 1, 0, 8'h33, 1);
        do_reset();
        send(8'h00, 1, 0, 8'h96, 1); chk("rs_b0", 32'(b.out_data), 32'h60);
        send(8'h00, 0, 1, 8'h00, 0); chk("rs_b1", 32'(b.out_data), 32'h09);

        for (int i = 0; i < 3000; i++) begin
            b.in_valid = ($urandom_range(3) != 0);
            b.out_ready = ($urandom_range(9) < 7);
            b.in_data = 8'($urandom);
            b.in_sop = in_pkt ? ($urandom_range(19) == 0) : ($urandom_range(9) != 0);
            b.in_eop = ($urandom_range(3) == 0);
            b.field_in = 8'($urandom);
            b.field_en = ($urandom_range(4) != 0);
            step();
        end
        b.in_valid = 1'b0;
        b.out_ready = 1'b1;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/field_writer.md
Name: field_writer

Overview:
- Streaming packet field rewriter: overwrites packet bits [END:START] with a supplied value while the packet flows beat-by-beat through a valid/ready stream.
- Write-side counterpart to the bit-field selector; used in the action stage to rewrite header fields (MAC, VLAN, TTL) after a match.
- Single registered pipeline stage; zero bubbles under continuous flow.

Parameters:
- W, 32, stream data width in bits per beat.
- START, 2, lowest packet bit index of the field (packet-absolute).
- END, 9, highest packet bit index of the field; END >= START.
- MAX_BEATS, 64, beat counter saturation limit; END < MAX_BEATS*W is required.
- Derived: FW = END-START+1; CW = clog2(MAX_BEATS+1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  W  packet beat; beat n carries packet bits [n*W+W-1 : n*W].
- in_sop  in  1  first beat of packet.
- in_eop  in  1  last beat of packet.
- in_valid  in  1  beat present.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- field_in  in  FW  replacement value; sampled only on an accepted SOP beat.
- field_en  in  1  rewrite enable; sampled with field_in.
- out_data  out  W  modified beat.
- out_sop  out  1  registered in_sop.
- out_eop  out  1  registered in_eop.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts.
- err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset: out_valid=0, out_data=0, out_sop=0, out_eop=0, err=0; FSM=IDLE; beat_cnt=0; captured field and enable cleared. in_ready=1 in the cycle after reset.
- Reset mid-packet discards the held beat and the packet context with no flush. Downstream sees the packet truncated without EOP.
- in_ready = !out_valid || out_ready (combinational). Latency is 1 cycle from accept to out_valid.
- On an accepted beat, the output register loads the modified beat, and out_valid is set. Otherwise, if out_ready is high, out_valid clears.
- out_* are held stable while out_valid && !out_ready.
- FSM has two states, IDLE and PKT.
- IDLE: an accepted SOP beat captures field_in/field_en and uses beat index 0. If the beat is not EOP, go to PKT with beat_cnt=1.
- IDLE: an accepted non-SOP beat passes through unmodified, pulses err, and leaves the state at IDLE.
- PKT: each accepted beat uses the index beat_cnt, then beat_cnt increments, saturating at MAX_BEATS. An EOP beat returns the FSM to IDLE.
- PKT: an accepted SOP beat pulses err and is treated as a new packet (recapture field, index 0).
- A single-beat packet (SOP and EOP together) is rewritten and the FSM stays in IDLE.
- Rewrite rule: for each lane bit j, p = idx*W + j. If the enable is set and START <= p <= END, out bit j = field[p-START]; otherwise out bit j = in bit j.
- The field may span any number of beats. Beats beyond END are unmodified. Beats at the saturated index are never rewritten.
- err is registered, asserted for one cycle in the cycle after the offending accept.

Test Plan:
- W=8, START=4, END=11, field=0xA5, en=1; 3-beat packet of 0x00 -> out 0x50, 0x0A, 0x00, with SOP on beat 0 and EOP on beat 2.
- Same config, in_data 0xFF each beat, en=0 -> out 0xFF, 0xFF, 0xFF unchanged.
- Defaults (W=32, START=2, END=9), single SOP+EOP beat 0xFFFFFFFF, field=0x000 -> out 0xFFFFFC03, FSM stays IDLE.
- Backpressure: out_ready held low for 5 cycles mid-packet -> in_ready=0, out_data stable, no beat lost or duplicated. Continuous flow with out_ready=1 gives 1 beat/cycle.
- Framing: SOP in PKT -> err pulse, new field applied from beat 0. Non-SOP beat in IDLE -> err pulse, passed unmodified.
- Reset asserted while out_valid=1 mid-packet -> next cycle out_valid=0. Next packet rewritten from index 0 with the new field.
